// File: rtl/axis_mux_sched.sv
// rtl/axis_mux_sched.sv - round-robin packet scheduler driving an AXI-Stream mux
//
// Watches the mux input handshakes and picks which input the mux forwards.
// It grants QUANTUM packets per turn and never switches in the middle of a packet.
//
// Optional feature: define AXIS_MUX_SCHED_STATS_EN to build the per-port
// completed-packet counters. Without it, stat_pkt_count is tied to zero.
//
// Parameters:
//   S_COUNT    - number of mux inputs (>= 2)
//   QUANTUM    - packets granted per turn (>= 1)
//   STAT_WIDTH - width of each per-port packet counter
//
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset
//   s_tvalid       - snoop of mux input tvalid, one bit per port
//   s_tready       - snoop of mux input tready, one bit per port
//   s_tlast        - snoop of mux input tlast, one bit per port
//   port_mask      - 1 = port may be granted
//   enable         - mux enable (registered)
//   sel            - mux select (registered)
//   grant          - one-hot current grant, zero when idle (registered)
//   busy           - high while a port is granted (registered)
//   stat_pkt_count - per-port completed-packet counts, port i at [i*STAT_WIDTH +: STAT_WIDTH]

module axis_mux_sched #(
   parameter int S_COUNT    = 4,
   parameter int QUANTUM    = 1,
   parameter int STAT_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_COUNT-1:0]            s_tvalid,
   input  logic [S_COUNT-1:0]            s_tready,
   input  logic [S_COUNT-1:0]            s_tlast,
   input  logic [S_COUNT-1:0]            port_mask,
   output logic                          enable,
   output logic [$clog2(S_COUNT)-1:0]    sel,
   output logic [S_COUNT-1:0]            grant,
   output logic                          busy,
   output logic [S_COUNT*STAT_WIDTH-1:0] stat_pkt_count
);

   localparam int SEL_W = $clog2(S_COUNT);
   localparam int QW    = $clog2(QUANTUM + 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_d;
   logic [SEL_W-1:0]   last_grant_q, last_grant_d;
   logic [QW-1:0]      pkt_cnt_q, pkt_cnt_d;
   logic [QW-1:0]      pkt_inc;
   logic               in_frame_q, in_frame_d;
   logic               enable_d, busy_d;
   logic [S_COUNT-1:0] grant_d;

   logic [S_COUNT-1:0] req;
   logic               arb_found;
   logic [SEL_W-1:0]   arb_idx;
   logic               beat, eop, rearb;

   assign req     = s_tvalid & port_mask;
   assign beat    = (state_q == ST_BUSY) && s_tvalid[sel] && s_tready[sel];
   assign eop     = beat && s_tlast[sel];
   assign pkt_inc = pkt_cnt_q + 1'b1;

   // Round-robin search beginning just after the last granted port.
   // The last granted port is checked last.
   always_comb begin
      int               cand;
      logic [SEL_W-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 1; i <= S_COUNT; i++) begin
         cand     = (int'(last_grant_q) + i) % S_COUNT;
         cand_idx = SEL_W'(cand);
         if (!arb_found && req[cand_idx]) begin
            arb_found = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   // Next-state logic.
   // last_grant follows every grant, so while BUSY it always equals sel.
   // Re-arbitration therefore starts the search just after the port being left.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel;
      pkt_cnt_d    = pkt_cnt_q;
      in_frame_d   = in_frame_q;
      last_grant_d = last_grant_q;
      rearb        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               state_d      = ST_BUSY;
               sel_d        = arb_idx;
               pkt_cnt_d    = '0;
               last_grant_d = arb_idx;
            end
         end
         default: begin
            if (eop) begin
               in_frame_d = 1'b0;
               if (pkt_inc == QW'(QUANTUM) || !port_mask[sel]) begin
                  rearb = 1'b1;
               end else begin
                  pkt_cnt_d = pkt_inc;
               end
            end else if (beat) begin
               in_frame_d = 1'b1;
            end else if (!in_frame_q && !s_tvalid[sel]) begin
               // The granted port has gone quiet between packets, so move on.
               rearb = 1'b1;
            end
            if (rearb) begin
               pkt_cnt_d = '0;
               if (arb_found) begin
                  sel_d        = arb_idx;
                  last_grant_d = arb_idx;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
      endcase
   end

   // Output decode from the next state; the results are registered below.
   always_comb begin
      enable_d = (state_d == ST_BUSY);
      busy_d   = (state_d == ST_BUSY);
      grant_d  = '0;
      if (state_d == ST_BUSY) begin
         grant_d[sel_d] = 1'b1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sel          <= '0;
         last_grant_q <= SEL_W'(S_COUNT - 1);
         pkt_cnt_q    <= '0;
         in_frame_q   <= 1'b0;
         enable       <= 1'b0;
         busy         <= 1'b0;
         grant        <= '0;
      end else begin
         state_q      <= state_d;
         sel          <= sel_d;
         last_grant_q <= last_grant_d;
         pkt_cnt_q    <= pkt_cnt_d;
         in_frame_q   <= in_frame_d;
         enable       <= enable_d;
         busy         <= busy_d;
         grant        <= grant_d;
      end
   end

`ifdef AXIS_MUX_SCHED_STATS_EN
   logic [STAT_WIDTH-1:0] stat_cnt_q [S_COUNT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < S_COUNT; i++) begin
            stat_cnt_q[i] <= '0;
         end
      end else if (eop) begin
         stat_cnt_q[sel] <= stat_cnt_q[sel] + 1'b1;
      end
   end

   for (genvar g = 0; g < S_COUNT; g++) begin : g_stat
      assign stat_pkt_count[g*STAT_WIDTH +: STAT_WIDTH] = stat_cnt_q[g];
   end
`else
   assign stat_pkt_count = '0;
`endif

endmodule

// File: doc/axis_mux_sched.md
AXIS_MUX_SCHED -- requirements
Module: axis_mux_sched

Interface
REQ-001 SHALL have parameter S_COUNT, default 4: number of mux inputs; minimum 2.
REQ-002 SHALL have parameter QUANTUM, default 1: packets granted per turn; minimum 1.
REQ-003 SHALL have parameter STAT_WIDTH, default 16: width of each per-port packet counter.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port s_tvalid, input, S_COUNT: snoop of the mux input tvalid vector.
REQ-007 SHALL have port s_tready, input, S_COUNT: snoop of the mux input tready vector.
REQ-008 SHALL have port s_tlast, input, S_COUNT: snoop of the mux input tlast vector.
REQ-009 SHALL have port port_mask, input, S_COUNT: 1 = port eligible for grant.
REQ-010 SHALL have port enable, output, 1: drives mux enable.
REQ-011 SHALL have port sel, output, $clog2(S_COUNT): drives mux sel.
REQ-012 SHALL have port grant, output, S_COUNT: one-hot current grant; zero when idle.
REQ-013 SHALL have port busy, output, 1: high in BUSY state.
REQ-014 SHALL have port stat_pkt_count, output, S_COUNT*STAT_WIDTH: per-port completed-packet counts; port i at [i*STAT_WIDTH +: STAT_WIDTH].

Function
REQ-015 SHALL drive enable, sel, grant and busy directly from registers.
REQ-016 SHALL define eligible requests as s_tvalid & port_mask.
REQ-017 SHALL implement two states, IDLE and BUSY; IDLE: enable=0, grant=0.
REQ-018 SHALL arbitrate round-robin: search starts at last_grant+1 and wraps modulo S_COUNT; last_grant participates last.
REQ-019 SHALL, in IDLE with any eligible request at cycle N, enter BUSY with enable=1, sel=winner and packet count 0 at cycle N+1.
REQ-020 SHALL define beat = s_tvalid[sel] & s_tready[sel] and eop = beat & s_tlast[sel], evaluated only in BUSY.
REQ-021 SHALL track in_frame: set on beat without tlast, cleared on eop.
REQ-022 SHALL, on eop, increment the packet count; when it reaches QUANTUM, or port_mask[sel]=0, re-arbitrate in the same cycle: winner -> BUSY with new sel and count 0; no request -> IDLE.
REQ-023 SHALL, on eop with quantum remaining and port still masked in, keep sel unchanged.
REQ-024 SHALL, in BUSY with in_frame=0 and s_tvalid[sel]=0, re-arbitrate exactly as in REQ-022.
REQ-025 SHALL never change sel or drop enable while in_frame=1, including after port_mask[sel] is cleared mid-packet.
REQ-026 SHALL update last_grant to sel on every re-arbitration.

Reset
REQ-027 SHALL, while rst_n=0, force IDLE: enable=0, sel=0, grant=0, busy=0, in_frame=0, packet count 0, last_grant=S_COUNT-1, all stat counters 0.
REQ-028 SHALL, after reset mid-packet, resume in IDLE with port 0 highest priority; the partial packet is not counted.

Configuration
REQ-029 SHALL provide macro AXIS_MUX_SCHED_STATS_EN.
REQ-030 SHALL, with AXIS_MUX_SCHED_STATS_EN defined, increment counter[sel] by 1 on each eop, wrapping modulo 2^STAT_WIDTH.
REQ-031 SHALL, without AXIS_MUX_SCHED_STATS_EN, tie stat_pkt_count to zero and instantiate no counter registers.

Verification
REQ-032 SHALL cover: reset release, s_tvalid=4'b0100 at cycle N -> enable=1, sel=2, grant=4'b0100 at cycle N+1.
REQ-033 SHALL cover: QUANTUM=1, all four ports streaming 1-beat packets -> sel sequence 0,1,2,3,0 with no idle cycle between packets.
REQ-034 SHALL cover: QUANTUM=2, ports 0 and 1 valid -> two packets from port 0, then two from port 1.
REQ-035 SHALL cover: port_mask[sel] cleared during a 5-beat packet -> sel held until eop, then next eligible port granted.
REQ-036 SHALL cover: rst_n low mid-packet, then released with s_tvalid=4'b1111 -> sel=0 first; with STATS_EN, 300 packets on port 3 at STAT_WIDTH=8 -> count 44.
